seg_serial_tx: RTL

- Serial transmitter for the 64-bit segment-pattern bus that the hex-to-seven-segment decode stage produces (8 digits × {a,b,c,d,e,f,g,p}).
- Shifts the frame MSB-first into the board's cascaded 74HC595-style shift registers using a clock, data and latch line.
- One `start` request sends one full frame and then pulses the latch.
- Sits between the segment decoder and the board display pins.

---
 rtl/seg_serial_tx.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seg_serial_tx.sv
// Serial transmitter for the segment-pattern frame. Shifts the frame
// MSB-first out on sclk/sdat into cascaded 595-style shift registers, then
// pulses slatch to transfer the frame to their output registers.
module seg_serial_tx #(
    parameter int DATA_W = 64,
    parameter int DIV    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] seg_data,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              sdat,
    output logic              slatch
);

    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DONE
    } state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] shreg, shreg_nx;
    logic [BCW-1:0]    bit_cnt, bit_cnt_nx;
    logic [DCW-1:0]    div_cnt, div_cnt_nx;
    logic              busy_nx, done_nx, sclk_nx, sdat_nx, slatch_nx;
    logic              div_last;

    assign div_last = (div_cnt == DIV_LAST);

    // State, counters, shift register and all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sclk    <= 1'b0;
            sdat    <= 1'b0;
            slatch  <= 1'b0;
        end else begin
            state   <= state_nx;
            shreg   <= shreg_nx;
            bit_cnt <= bit_cnt_nx;
            div_cnt <= div_cnt_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            sclk    <= sclk_nx;
            sdat    <= sdat_nx;
            slatch  <= slatch_nx;
        end
    end

    // Next-state and next-output logic; everything holds unless changed,
    // except done which is a single-cycle pulse.
    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_cnt_nx = bit_cnt;
        div_cnt_nx = div_cnt;
        busy_nx    = busy;
        done_nx    = 1'b0;
        sclk_nx    = sclk;
        sdat_nx    = sdat;
        slatch_nx  = slatch;

        case (state)
            IDLE: begin
                if (start) begin
                    shreg_nx   = seg_data;
                    sdat_nx    = seg_data[DATA_W-1];
                    busy_nx    = 1'b1;
                    bit_cnt_nx = '0;
                    div_cnt_nx = '0;
                    state_nx   = SHIFT_LO;
                end
            end

            SHIFT_LO: begin
                if (div_last) begin
                    sclk_nx    = 1'b1;
                    div_cnt_nx = '0;
                    state_nx   = SHIFT_HI;
                end else begin
                    div_cnt_nx = div_cnt + DCW'(1);
                end
            end

            SHIFT_HI: begin
                if (div_last) begin
                    // Falling sclk edge: the only place sdat is allowed to move.
                    sclk_nx    = 1'b0;
                    div_cnt_nx = '0;
                    if (bit_cnt == BIT_LAST) begin
                        slatch_nx = 1'b1;
                        state_nx  = LATCH;
                    end else begin
                        shreg_nx   = shreg << 1;
                        sdat_nx    = shreg[DATA_W-2];
                        bit_cnt_nx = bit_cnt + BCW'(1);
                        state_nx   = SHIFT_LO;
                    end
                end else begin
                    div_cnt_nx = div_cnt + DCW'(1);
                end
            end

            LATCH: begin
                if (div_last) begin
                    slatch_nx  = 1'b0;
                    busy_nx    = 1'b0;
                    done_nx    = 1'b1;
                    div_cnt_nx = '0;
                    state_nx   = DONE;
                end else begin
                    div_cnt_nx = div_cnt + DCW'(1);
                end
            end

            DONE: begin
                // start is deliberately not looked at here.
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
